mem_master: RTL and testbench
=============================

# mem_master

Bus-master sequencer that drives the single-port `memory` block's strobe interface (`addr_en`/`in_en`/`out_en`) on behalf of a requester such as the CPU fetch or load/store unit. It accepts one read or write request per valid/ready handshake and splits it into the memory's address phase and data phase. It returns a response (read data or write acknowledge) on a valid/ready channel. It shadows the memory's MAR so that it can skip the address phase when the address is unchanged.

## Interface
- `ADDR_W`, 16, address width; matches memory `addr`
- `DATA_W`, 16, data width; matches memory `in`/`out`
- `MAR_TRACK`, 1, 1 = skip the address phase on a shadow-MAR hit; 0 = always issue the address phase
- `clk` in 1: the only clock
- `rst_n` in 1: asynchronous active-low reset
- `req_valid` in 1: request present
- `req_ready` out 1: block can accept a request
- `req_we` in 1: 1 = write, 0 = read
- `req_addr` in ADDR_W: word address
- `req_wdata` in DATA_W: write data
- `rsp_valid` out 1: response present
- `rsp_ready` in 1: consumer takes the response
- `rsp_we` out 1: echo of the request's `req_we`
- `rsp_rdata` out DATA_W: read data; holds its last value on writes
- `addr_en` out 1: to memory `addr_en`
- `addr` out ADDR_W: to memory `addr`
- `in_en` out 1: to memory `in_en`
- `in` out DATA_W: to memory `in`
- `out_en` out 1: to memory `out_en`
- `out` in DATA_W: from memory `out`

## Operation
- FSM states: IDLE, ADDR, WRITE, READ, CAPT, RESP. Outputs are Moore-decoded from the state plus the request registers.
- **IDLE**
  - `req_ready`=1. On `req_valid`, latch `we`, `addr` and `wdata` into request registers.
  - Next state is ADDR, unless `MAR_TRACK`=1 and `mar_known`=1 and `mar_q`==`req_addr`.
  - On that hit, go straight to WRITE or READ.
- **ADDR**: `addr_en`=1, `addr`=latched address. Set `mar_q`←address and `mar_known`←1. Next state is WRITE or READ.
- **WRITE**: `in_en`=1, `in`=latched wdata. Next state is RESP.
- **READ**: `out_en`=1. Next state is CAPT.
- **CAPT**: memory `out` is now valid; `rsp_rdata`←`out`. Next state is RESP.
- **RESP**
  - `rsp_valid`=1. On `rsp_ready`, go to IDLE.
  - No new request is accepted in the same cycle; `req_ready` is 0 outside IDLE.
- Strobe exclusivity: at most one of `addr_en`/`in_en`/`out_en` is high in any cycle.
- `addr`/`in` equal the latched values whenever their strobe is high, and hold their last value otherwise.
- The shadow MAR changes only in ADDR; no other path alters the memory MAR.
- Address compare is full ADDR_W equality; there is no wrap or masking.

## Timing
- Reset (async assert, sync release):
  - state=IDLE
  - `req_ready`=1
  - `rsp_valid`=0
  - `rsp_we`=0
  - `rsp_rdata`=0
  - `addr_en`=`in_en`=`out_en`=0
  - `addr`=0, `in`=0
  - `mar_q`=0, `mar_known`=0
- Reset mid-operation aborts the transaction with no response. The memory MAR is then treated as unknown, so the next request always issues ADDR.
- Latency is measured from the accepting edge to `rsp_valid` high, with `rsp_ready` held at 1:
  - read miss: 3 cycles (ADDR, READ, CAPT)
  - read hit: 2 cycles
  - write miss: 2 cycles
  - write hit: 1 cycle
- `rsp_valid`/`rsp_we`/`rsp_rdata` are stable from assertion until the edge on which `rsp_ready`=1.
- Back-to-back throughput: one transaction per latency+2 cycles (RESP cycle plus the IDLE accept cycle).
- `req_*` values are sampled only on the accepting edge; later changes are ignored.

## Structure
- Shared package `tiny16_pkg`:
  - `mem_master_state_t` enum (IDLE, ADDR, WRITE, READ, CAPT, RESP)
  - `ADDR_W`/`DATA_W` defaults shared with `memory`
- Single flat module; no sub-module. Shadow MAR and request registers live inline.

## Test plan
- **Read miss after reset.** Preload mem[0x10]=0xBEEF, read 0x10.
  - `addr_en` high for 1 cycle with `addr`=0x10, then `out_en` for 1 cycle.
  - `rsp_valid` 3 cycles after accept with `rsp_rdata`=0xBEEF, `rsp_we`=0.
- **Write then read same address.** Write 0x22←0x1234, then read 0x22.
  - Write takes a 2-cycle miss; the read is a hit with no `addr_en` and returns 0x1234 in 2 cycles.
- **Address change.** Read 0x22 then read 0x23: the second read issues `addr_en` with 0x23 and takes 3 cycles.
- **MAR_TRACK=0.** Repeated reads of 0x05 issue `addr_en` every time; latency is always 3.
- **Response backpressure.** Hold `rsp_ready`=0 for 5 cycles.
  - `rsp_valid` and `rsp_rdata` stay stable and `req_ready`=0 throughout.
  - A release accepts the next request 1 cycle later.
- **Reset mid-operation.** Assert `rst_n`=0 during READ.
  - Outputs go to reset values immediately and no response is issued.
  - The next read of the same address issues `addr_en`.

Source files
------------

// File: rtl/tiny16_pkg.sv
// Shared definitions for the tiny16 memory subsystem.
// - TINY16_ADDR_W / TINY16_DATA_W: default bus widths shared with `memory`
// - mem_master_state_t: sequencer states of mem_master
package tiny16_pkg;

  localparam int unsigned TINY16_ADDR_W = 16;
  localparam int unsigned TINY16_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    CAPT  = 3'd4,
    RESP  = 3'd5
  } mem_master_state_t;

endpackage

// File: rtl/mem_master.sv
// Bus-master sequencer for the single-port `memory` strobe interface.
// Accepts one read/write request per valid/ready handshake, splits it into
// the memory address phase (addr_en) and data phase (in_en / out_en), and
// returns read data or a write acknowledge on a valid/ready response channel.
// A shadow copy of the memory MAR allows the address phase to be skipped when
// the requested address is already loaded (MAR_TRACK=1).
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready/req_we/
//   req_addr/req_wdata                 request channel
//   rsp_valid/rsp_ready/rsp_we/
//   rsp_rdata                          response channel
//   addr_en/addr, in_en/in, out_en/out memory strobe interface
module mem_master
  import tiny16_pkg::*;
#(
  parameter int unsigned ADDR_W    = TINY16_ADDR_W,
  parameter int unsigned DATA_W    = TINY16_DATA_W,
  parameter bit          MAR_TRACK = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              addr_en,
  output logic [ADDR_W-1:0] addr,
  output logic              in_en,
  output logic [DATA_W-1:0] in,
  output logic              out_en,
  input  logic [DATA_W-1:0] out
);

  mem_master_state_t state, state_nxt;

  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] in_q;
  logic [ADDR_W-1:0] mar_q;
  logic              mar_known;
  logic              rsp_we_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              mar_hit;

  assign mar_hit = MAR_TRACK && mar_known && (mar_q == req_addr);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = mar_hit ? (req_we ? WRITE : READ) : ADDR;
      ADDR:    state_nxt = we_q ? WRITE : READ;
      WRITE:   state_nxt = RESP;
      READ:    state_nxt = CAPT;
      CAPT:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    addr_en   = 1'b0;
    in_en     = 1'b0;
    out_en    = 1'b0;
    unique case (state)
      IDLE:    req_ready = 1'b1;
      ADDR:    addr_en   = 1'b1;
      WRITE:   in_en     = 1'b1;
      READ:    out_en    = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // addr/in are separate registers loaded on entry to their strobe state, so
  // the memory-facing buses only move when their strobe rises. addr_q doubles
  // as the latched request address: on a MAR hit it already equals req_addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      addr_q      <= '0;
      in_q        <= '0;
      mar_q       <= '0;
      mar_known   <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        wdata_q <= req_wdata;
      end
      if (state == IDLE && state_nxt == ADDR) begin
        addr_q <= req_addr;
      end
      if (state_nxt == WRITE && state != WRITE) begin
        in_q <= (state == IDLE) ? req_wdata : wdata_q;
      end
      if (state == ADDR) begin
        mar_q     <= addr_q;
        mar_known <= 1'b1;
      end
      if (state == CAPT) begin
        rsp_rdata_q <= out;
      end
      if (state_nxt == RESP && state != RESP) begin
        rsp_we_q <= we_q;
      end
    end
  end

  assign addr      = addr_q;
  assign in        = in_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_master.sv
// Scoreboard bench for mem_master: a driver issues requests and pushes the
// expected response into a queue; a negedge monitor checks strobes, latency
// and response content against it. A second instance with MAR_TRACK=0 is
// exercised with a short directed sequence.
module tb_mem_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_we;
  logic [15:0] rsp_rdata;
  logic        addr_en, in_en, out_en;
  logic [15:0] addr, mem_in, mem_out;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [15:0] b_req_addr, b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_we;
  logic [15:0] b_rsp_rdata;
  logic        b_addr_en, b_in_en, b_out_en;
  logic [15:0] b_addr, b_mem_in, b_mem_out;

  mem_master #(.ADDR_W(16), .DATA_W(16), .MAR_TRACK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata),
    .addr_en(addr_en), .addr(addr), .in_en(in_en), .in(mem_in),
    .out_en(out_en), .out(mem_out)
  );

  mem_master #(.ADDR_W(16), .DATA_W(16), .MAR_TRACK(1'b0)) dut_nt (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_we(b_rsp_we),
    .rsp_rdata(b_rsp_rdata),
    .addr_en(b_addr_en), .addr(b_addr), .in_en(b_in_en), .in(b_mem_in),
    .out_en(b_out_en), .out(b_mem_out)
  );

  // Behavioural single-port memories attached to the strobe interfaces.
  logic [15:0] mem [0:65535];
  logic [15:0] mmar = '0;
  always @(posedge clk) begin
    if (addr_en) mmar <= addr;
    if (in_en)   mem[mmar] <= mem_in;
    if (out_en)  mem_out <= mem[mmar];
  end

  logic [15:0] b_mar = '0;
  always @(posedge clk) begin
    if (b_addr_en) b_mar <= b_addr;
    if (b_out_en)  b_mem_out <= b_mar ^ 16'h5A5A;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the memory holds, and whether/what the memory MAR
  // is known to contain.
  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          lat;
    int          naddr;
  } exp_t;

  exp_t        q[$];
  logic [15:0] ref_mem [0:65535];
  bit          m_known = 1'b0;
  logic [15:0] m_mar = '0;
  logic [15:0] m_last_rdata = '0;

  function automatic exp_t predict(bit we, logic [15:0] a, logic [15:0] d);
    exp_t e;
    bit   hit;
    hit     = m_known && (m_mar == a);
    e.we    = we;
    e.addr  = a;
    e.wdata = d;
    e.lat   = (we ? 1 : 2) + (hit ? 0 : 1);
    e.naddr = hit ? 0 : 1;
    if (we) begin
      ref_mem[a] = d;
      e.rdata    = m_last_rdata;
    end else begin
      e.rdata      = ref_mem[a];
      m_last_rdata = e.rdata;
    end
    m_known = 1'b1;
    m_mar   = a;
    return e;
  endfunction

  bit          force_low = 1'b0;
  bit          rand_bp = 1'b0;
  always @(posedge clk) begin
    #1;
    rsp_ready = force_low ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  // Monitor
  bit          in_txn = 1'b0;
  bit          resp_seen = 1'b0;
  bit          done_prev = 1'b0;
  int          cyc = 0;
  int          naddr_seen = 0;
  logic        h_we;
  logic [15:0] h_rdata;
  exp_t        me;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done_prev) check("req_ready_after_rsp", req_ready, 1);
      done_prev = 1'b0;
      if (addr_en || in_en || out_en)
        check("strobe_exclusive", $countones({addr_en, in_en, out_en}), 1);
      if (in_txn && !resp_seen && !rsp_valid) begin
        cyc++;
        if (q.size() > 0) begin
          if (addr_en) begin
            naddr_seen++;
            check("addr_value", addr, q[0].addr);
          end
          if (in_en) check("in_value", mem_in, q[0].wdata);
          if (in_en || out_en) check("strobe_direction", in_en, q[0].we);
        end
      end
      if (rsp_valid) begin
        if (!resp_seen) begin
          if (q.size() == 0) begin
            check("unexpected_rsp", 0, 1);
          end else begin
            me = q.pop_front();
            check("latency", cyc, me.lat);
            check("addr_phases", naddr_seen, me.naddr);
            check("rsp_we", rsp_we, me.we);
            check("rsp_rdata", rsp_rdata, me.rdata);
          end
          resp_seen = 1'b1;
          h_we      = rsp_we;
          h_rdata   = rsp_rdata;
        end else begin
          check("hold_rsp_we", rsp_we, h_we);
          check("hold_rsp_rdata", rsp_rdata, h_rdata);
          check("req_ready_busy", req_ready, 0);
        end
        if (rsp_ready) begin
          resp_seen = 1'b0;
          in_txn    = 1'b0;
          done_prev = 1'b1;
        end
      end else if (resp_seen) begin
        check("rsp_dropped", 0, 1);
        resp_seen = 1'b0;
        in_txn    = 1'b0;
      end
      if (req_valid && req_ready) begin
        in_txn     = 1'b1;
        cyc        = 0;
        naddr_seen = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic do_req(bit we, logic [15:0] a, logic [15:0] d);
    bit acc;
    acc       = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = 1'b1;
        q.push_back(predict(we, a, d));
      end
      @(posedge clk);
      #1;
    end
    if (!acc) check("req_accept_timeout", 0, 1);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(posedge clk);
      #1;
      idle = (q.size() == 0) && !in_txn;
    end
    if (!idle) check("drain_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_we"}, rsp_we, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_strobes"}, {addr_en, in_en, out_en}, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_in"}, mem_in, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    int bcyc, bna;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'(i) ^ 16'hC3A5;
      ref_mem[i] = mem[i];
    end
    mem[16'h0010]     = 16'hBEEF;
    ref_mem[16'h0010] = 16'hBEEF;

    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    b_rsp_ready = 1'b1;
    rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // MAR_TRACK=0: every access issues the address phase.
    for (int k = 0; k < 3; k++) begin
      b_req_valid = 1'b1;
      b_req_we    = 1'b0;
      b_req_addr  = 16'h0005;
      @(negedge clk);
      check("nt_req_ready", b_req_ready, 1);
      @(posedge clk);
      #1;
      b_req_valid = 1'b0;
      b_req_addr  = 16'hFFFF;
      bcyc  = 0;
      bna   = 0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        @(negedge clk);
        if (b_rsp_valid) found = 1'b1;
        else begin
          bcyc++;
          if (b_addr_en) bna++;
        end
      end
      check("nt_latency", bcyc, 3);
      check("nt_addr_phases", bna, 1);
      check("nt_rsp_rdata", b_rsp_rdata, 16'h0005 ^ 16'h5A5A);
      @(posedge clk);
      #1;
    end

    // Directed sequence: read miss, write miss, read hit, address change.
    do_req(1'b0, 16'h0010, 16'h0000);
    wait_idle();
    do_req(1'b1, 16'h0022, 16'h1234);
    do_req(1'b0, 16'h0022, 16'h0000);
    do_req(1'b0, 16'h0023, 16'h0000);
    wait_idle();

    // Response backpressure for 5 cycles.
    force_low = 1'b1;
    do_req(1'b0, 16'h0023, 16'h0000);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (rsp_valid) found = 1'b1;
    end
    if (!found) check("bp_rsp_timeout", 0, 1);
    repeat (5) @(negedge clk);
    force_low = 1'b0;
    wait_idle();
    do_req(1'b1, 16'h0030, 16'hA5A5);
    wait_idle();

    // Reset during READ aborts the transaction and forgets the MAR.
    do_req(1'b0, 16'h0040, 16'h0000);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (out_en) found = 1'b1;
    end
    if (!found) check("read_phase_timeout", 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    q.delete();
    in_txn       = 1'b0;
    resp_seen    = 1'b0;
    done_prev    = 1'b0;
    m_known      = 1'b0;
    m_last_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_rsp_after_reset", rsp_valid, 0);
    end
    @(posedge clk);
    #1;
    do_req(1'b0, 16'h0040, 16'h0000);
    wait_idle();

    // Randomized traffic over a small address window to mix hits and misses.
    rand_bp = 1'b1;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0)
        do_req(1'($urandom), 16'($urandom), 16'($urandom));
      else
        do_req(1'($urandom), 16'h0020 + 16'($urandom_range(0, 3)), 16'($urandom));
    end
    wait_idle();
    rand_bp = 1'b0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
